progmem_prefetch: RTL and testbench
===================================

# progmem_prefetch

Single-entry sequential instruction prefetch buffer between the PicoRV32 native memory bus and the program ROM slave.
- On every instruction fetch, it speculatively fetches the next word into a one-word buffer.
- A later sequential fetch is then answered with zero wait states.
- Data reads and non-sequential fetches are forwarded to the ROM unchanged.
- The ROM slave answers a request one cycle after seeing `valid`. Its `ready` is just `valid` delayed, so this block must leave a one-cycle gap with `valid` low between downstream requests.

## Interface
- `MEM_SIZE_BITS`, default 10: ROM size in 32-bit words. It defines the last-word boundary.
- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `s_valid`  in  1: CPU request. It is held until `s_ready`. It is already address-decoded to the ROM window.
- `s_instr`  in  1: 1 means instruction fetch, 0 means data read.
- `s_addr`  in  32: CPU byte address. Bits [1:0] are ignored.
- `s_ready`  out  1: combinational completion strobe to the CPU.
- `s_rdata`  out  32: read data. Valid only when `s_ready`=1.
- `m_valid`  out  1: registered request to the ROM.
- `m_addr`  out  32: registered ROM address, with [1:0]=0.
- `m_ready`  in  1: ROM completion.
- `m_rdata`  in  32: ROM data, valid with `m_ready`.

## Operation
- **Buffer state:** `buf_valid`, `buf_addr[31:2]`, `buf_data[31:0]`, `pf_addr[31:2]`.
- **Hit** means `s_valid` & `s_instr` & `buf_valid` & (`s_addr[31:2]`==`buf_addr`).
- **Last word** means `s_addr[MEM_SIZE_BITS+1:2]` is all ones. No prefetch is ever issued past the last word, so there is no wrap-around.
- **State IDLE** (`m_valid`=0):
  - On a hit: `s_ready`=1 and `s_rdata`=`buf_data` in the same cycle. Clear `buf_valid`. If not the last word, set `pf_addr`=`buf_addr`+1 and go to PREFETCH; otherwise stay in IDLE.
  - On `s_valid` without a hit: load `m_addr`=`s_addr` and go to FETCH.
- **State FETCH** (`m_valid`=1):
  - `s_ready`=`m_ready` and `s_rdata`=`m_rdata` (pass-through).
  - On `m_ready`: if `s_instr` and not the last word, set `pf_addr`=`s_addr[31:2]`+1 and go to GAP; otherwise go to IDLE. The buffer is untouched.
- **State GAP** (`m_valid`=0):
  - `s_ready`=0, and any `s_valid` is held pending.
  - Load `m_addr`=`pf_addr` and go to PREFETCH unconditionally.
- **State PREFETCH** (`m_valid`=1), on `m_ready`:
  - If `s_valid` & `s_instr` & `s_addr[31:2]`==`pf_addr`: forward with `s_ready`=1 and `s_rdata`=`m_rdata`. The word is not buffered. If not the last word, set `pf_addr`+=1 and go to GAP; otherwise go to IDLE.
  - Otherwise: set `buf_addr`=`pf_addr`, `buf_data`=`m_rdata`, `buf_valid`=1, and go to IDLE. A pending mismatching request is evaluated in IDLE on the next cycle.
- **Data reads** (`s_instr`=0) never hit, never start a prefetch, and never modify the buffer.
- **`m_ready` outside FETCH and PREFETCH** is ignored.

## Timing
- **Reset values:** state=IDLE, `buf_valid`=0, `buf_data`=0, `m_valid`=0, `m_addr`=0, so `s_ready`=0 and `s_rdata`=0. An asynchronous assert mid-transaction forces these immediately, and any in-flight ROM result is dropped.
- **Hit latency:** 0 wait states (`s_ready` in the same cycle as `s_valid`).
- **Miss latency:** `s_valid` in cycle 0 gives `m_valid` in cycle 1 and `s_ready` in cycle 2.
- **Forwarded prefetch:** `s_ready` in the cycle `m_ready` arrives.
- **Downstream gap rule:** `m_valid` always drops for at least one cycle after any downstream completion. `m_valid` and `m_addr` are stable from request issue until `m_ready`.
- **Transition latency:**
  - Hit → PREFETCH: `m_valid` one cycle after the hit.
  - FETCH completion → GAP → PREFETCH: the next-word request is issued 2 cycles after completion.

## Structure
- Shared package `progmem_pkg` holds:
  - the 2-bit state encodings IDLE=0, FETCH=1, GAP=2, PREFETCH=3;
  - the ROM window base 32'h0010_0000 and mask 32'h0010_0000;
  - the default `MEM_SIZE_BITS`.
- Single module. No sub-module is warranted; the buffer is three registers.

## Test plan
- **Reset:** hold `rstn`=0 with `s_valid`=1 → `m_valid`=0, `s_ready`=0, `s_rdata`=0. After release, the first request is treated as a miss.
- **Cold miss:** instr fetch of 0x0010_0000; ROM model (1-cycle, word0=0x200106B7, word1=0x02040737) → `m_valid` in cycle 1 with `m_addr`=0x0010_0000; `s_ready` in cycle 2 with 0x200106B7; `m_valid` low in cycle 3; PREFETCH with `m_addr`=0x0010_0004 in cycle 4.
- **Sequential hit:** after the prefetch lands, fetch 0x0010_0004 → `s_ready`=1 in the same cycle with 0x02040737 and `m_valid`=0; the next cycle shows `m_valid`=1 with `m_addr`=0x0010_0008.
- **Branch during prefetch:** fetch 0x0010_0040 while PREFETCH of 0x0010_0008 is pending → no `s_ready` at prefetch completion; `buf_addr`=0x0010_0008; then a FETCH of 0x0010_0040 follows the mandatory gap and completes with `s_ready`.
- **Data read:** `s_instr`=0 read of 0x0010_064C → pass-through result, no PREFETCH follows, and buffer contents are unchanged (a following fetch of the previously buffered address still hits).
- **Last word and reset:** instr fetch of 0x0010_0FFC → completes and returns to IDLE with no prefetch. Assert `rstn` low during FETCH → `m_valid`=0 asynchronously and `buf_valid`=0.

Source files
------------

// File: rtl/progmem_pkg.sv
// Shared definitions for the program-ROM prefetch buffer: FSM encoding,
// ROM window constants and the default ROM size.
package progmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_GAP      = 2'd2,
    ST_PREFETCH = 2'd3
  } pf_state_t;

  localparam logic [31:0] ROM_BASE          = 32'h0010_0000;
  localparam logic [31:0] ROM_MASK          = 32'h0010_0000;
  localparam int unsigned MEM_SIZE_BITS_DEF = 10;

  function automatic logic [29:0] next_word(input logic [29:0] word);
    return word + 30'd1;
  endfunction

endpackage

// File: rtl/progmem_prefetch.sv
// Single-entry sequential instruction prefetch buffer between the CPU native
// memory bus and a one-cycle program ROM that needs a valid-low gap between requests.
module progmem_prefetch
  import progmem_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BITS = MEM_SIZE_BITS_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  input  logic        s_instr,
  input  logic [31:0] s_addr,
  output logic        s_ready,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  pf_state_t   state_r;
  logic        buf_valid_r;
  logic [29:0] buf_addr_r;
  logic [31:0] buf_data_r;
  logic [29:0] pf_addr_r;

  logic [29:0] req_word_s;
  logic        hit_s;
  logic        last_s;
  logic        pf_match_s;
  logic        unused_s;

  assign req_word_s = s_addr[31:2];
  assign hit_s      = s_valid & s_instr & buf_valid_r & (req_word_s == buf_addr_r);
  assign last_s     = &s_addr[MEM_SIZE_BITS+1:2];
  assign pf_match_s = s_valid & s_instr & (req_word_s == pf_addr_r);
  assign unused_s   = ^s_addr[1:0];

  // CPU-side response: buffer hit in IDLE, ROM pass-through while a request is out
  always_comb begin
    s_ready = 1'b0;
    s_rdata = buf_data_r;
    case (state_r)
      ST_IDLE: begin
        s_ready = hit_s;
        s_rdata = buf_data_r;
      end
      ST_FETCH: begin
        s_ready = m_ready;
        s_rdata = m_rdata;
      end
      ST_GAP: begin
        s_ready = 1'b0;
        s_rdata = buf_data_r;
      end
      ST_PREFETCH: begin
        s_ready = m_ready & pf_match_s;
        s_rdata = m_rdata;
      end
      default: begin
        s_ready = 1'b0;
        s_rdata = buf_data_r;
      end
    endcase
  end

  // Control FSM, ROM request registers and the one-word buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      buf_valid_r <= 1'b0;
      buf_addr_r  <= 30'd0;
      buf_data_r  <= 32'd0;
      pf_addr_r   <= 30'd0;
      m_valid     <= 1'b0;
      m_addr      <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            buf_valid_r <= 1'b0;
            if (!last_s) begin
              pf_addr_r <= next_word(buf_addr_r);
              m_addr    <= {next_word(buf_addr_r), 2'b00};
              m_valid   <= 1'b1;
              state_r   <= ST_PREFETCH;
            end
          end else if (s_valid) begin
            m_addr  <= {req_word_s, 2'b00};
            m_valid <= 1'b1;
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (s_instr && !last_s) begin
              pf_addr_r <= next_word(req_word_s);
              state_r   <= ST_GAP;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          // ROM ready is its valid delayed, so one idle cycle must separate requests
          m_addr  <= {pf_addr_r, 2'b00};
          m_valid <= 1'b1;
          state_r <= ST_PREFETCH;
        end
        ST_PREFETCH: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (pf_match_s) begin
              if (!last_s) begin
                pf_addr_r <= next_word(pf_addr_r);
                state_r   <= ST_GAP;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              buf_addr_r  <= pf_addr_r;
              buf_data_r  <= m_rdata;
              buf_valid_r <= 1'b1;
              state_r     <= ST_IDLE;
            end
          end
        end
        default: begin
          m_valid <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_progmem_prefetch.sv
// Self-checking bench for progmem_prefetch: one-cycle ROM model, request table
// with a scoreboard of expected data/wait states, and hand-timed corner sequences.
module tb_progmem_prefetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_instr;
  logic [31:0] s_addr;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        m_valid;
  logic [31:0] m_addr;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit sb_en    = 1'b0;

  typedef struct {
    int          idle;
    logic [31:0] addr;
    logic        instr;
    int          wait_c;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          wait_c;
    int          start;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  exp_t mon_e;

  logic        prev_mv  = 1'b0;
  logic        prev_mr  = 1'b0;
  logic        prev_rst = 1'b0;
  logic [31:0] prev_ma  = 32'd0;

  progmem_prefetch #(.MEM_SIZE_BITS(10)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_instr (s_instr),
    .s_addr  (s_addr),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_ready (m_ready),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [9:0] idx);
    case (idx)
      10'd0:   return 32'h200106B7;
      10'd1:   return 32'h02040737;
      default: return {12'hC0D, 10'd0, idx};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // ROM slave: answers one cycle after valid, ready is valid delayed
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    m_ready <= m_valid;
    m_rdata <= rom_word(m_addr[11:2]);
  end

  // Scoreboard: pop and compare on every CPU completion
  always @(negedge clk) begin
    if (rstn && sb_en && s_valid && s_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_ready addr=%h", s_addr);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("sb_data@%h", s_addr), s_rdata, mon_e.data);
        chk($sformatf("sb_wait@%h", s_addr), cyc - mon_e.start, mon_e.wait_c);
      end
    end
  end

  // Downstream protocol: gap after completion, request stable until ready
  always @(negedge clk) begin
    if (rstn && prev_rst) begin
      if (prev_mv && prev_mr) begin
        chk("gap_after_done", {31'd0, m_valid}, 32'd0);
      end else if (prev_mv) begin
        chk("req_hold_valid", {31'd0, m_valid}, 32'd1);
        chk("req_hold_addr", m_addr, prev_ma);
      end
    end
    prev_mv  <= m_valid;
    prev_mr  <= m_ready;
    prev_ma  <= m_addr;
    prev_rst <= rstn;
  end

  task automatic run_req(input int idle, input logic [31:0] addr, input logic instr,
                         input int exp_wait);
    exp_t e;
    bit   got;
    repeat (idle) @(posedge clk);
    if (idle > 0) #1;
    s_valid  = 1'b1;
    s_instr  = instr;
    s_addr   = addr;
    e.data   = rom_word(addr[11:2]);
    e.wait_c = exp_wait;
    e.start  = cyc;
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk);
      if (s_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL req_timeout addr=%h got=no_ready exp=ready", addr);
      if (sb_q.size() > 0) sb_q.delete(0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2, 32'h0010_064C, 1'b0, 2};
    vecs[1]  = '{0, 32'h0010_0044, 1'b1, 0};
    vecs[2]  = '{0, 32'h0010_0048, 1'b1, 1};
    vecs[3]  = '{0, 32'h0010_004C, 1'b1, 2};
    vecs[4]  = '{0, 32'h0010_0200, 1'b0, 5};
    vecs[5]  = '{0, 32'h0010_0050, 1'b1, 0};
    vecs[6]  = '{4, 32'h0010_0054, 1'b1, 0};
    vecs[7]  = '{0, 32'h0010_0300, 1'b1, 4};
    vecs[8]  = '{5, 32'h0010_0304, 1'b1, 0};
    vecs[9]  = '{0, 32'h0010_0FFC, 1'b1, 4};
    vecs[10] = '{2, 32'h0010_0308, 1'b1, 0};
    vecs[11] = '{3, 32'h0010_030C, 1'b1, 0};
    vecs[12] = '{0, 32'h0010_0310, 1'b0, 4};
    vecs[13] = '{1, 32'h0010_0310, 1'b1, 0};

    rstn    = 1'b0;
    s_valid = 1'b1;
    s_instr = 1'b1;
    s_addr  = 32'h0010_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_s_rdata", s_rdata, 32'd0);

    // cold miss, prefetch, sequential hit, branch while prefetch pending
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk); chk("cm_c0_mv", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("cm_c1_mv", {31'd0, m_valid}, 32'd1);
    chk("cm_c1_ma", m_addr, 32'h0010_0000);
    chk("cm_c1_rdy", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("cm_c2_rdy", {31'd0, s_ready}, 32'd1);
    chk("cm_c2_data", s_rdata, 32'h200106B7);
    @(posedge clk); #1; s_valid = 1'b0; @(negedge clk);
    chk("cm_c3_mv", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("cm_c4_mv", {31'd0, m_valid}, 32'd1);
    chk("cm_c4_ma", m_addr, 32'h0010_0004);
    @(posedge clk); #1; @(negedge clk);
    @(posedge clk); #1; s_valid = 1'b1; s_addr = 32'h0010_0004; @(negedge clk);
    chk("hit_rdy", {31'd0, s_ready}, 32'd1);
    chk("hit_data", s_rdata, 32'h02040737);
    chk("hit_mv", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1; s_addr = 32'h0010_0040; @(negedge clk);
    chk("hit_pf_mv", {31'd0, m_valid}, 32'd1);
    chk("hit_pf_ma", m_addr, 32'h0010_0008);
    chk("br_c7_rdy", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("br_pfdone_rdy", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("br_gap_mv", {31'd0, m_valid}, 32'd0);
    chk("br_buf_valid", {31'd0, dut.buf_valid_r}, 32'd1);
    chk("br_buf_addr", {2'b00, dut.buf_addr_r}, 32'h0004_0002);
    @(posedge clk); #1; @(negedge clk);
    chk("br_fetch_mv", {31'd0, m_valid}, 32'd1);
    chk("br_fetch_ma", m_addr, 32'h0010_0040);
    @(posedge clk); #1; @(negedge clk);
    chk("br_fetch_rdy", {31'd0, s_ready}, 32'd1);
    chk("br_fetch_data", s_rdata, rom_word(10'd16));
    @(posedge clk); #1; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    sb_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i].idle, vecs[i].addr, vecs[i].instr, vecs[i].wait_c);
    end
    sb_en = 1'b0;

    // last word gets no prefetch; async reset in FETCH drops everything
    repeat (4) @(posedge clk);
    #1; s_valid = 1'b1; s_instr = 1'b1; s_addr = 32'h0010_0FFC;
    @(negedge clk); chk("lw_c0_mv", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("lw_c1_mv", {31'd0, m_valid}, 32'd1);
    chk("lw_c1_ma", m_addr, 32'h0010_0FFC);
    @(posedge clk); #1; @(negedge clk);
    chk("lw_c2_rdy", {31'd0, s_ready}, 32'd1);
    chk("lw_c2_data", s_rdata, rom_word(10'h3FF));
    @(posedge clk); #1; s_valid = 1'b0; @(negedge clk);
    chk("lw_c3_mv", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("lw_c4_no_pf", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1; s_valid = 1'b1; s_addr = 32'h0010_0020;
    @(posedge clk); #2;
    chk("ar_pre_mv", {31'd0, m_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("ar_mv", {31'd0, m_valid}, 32'd0);
    chk("ar_ma", m_addr, 32'd0);
    chk("ar_rdy", {31'd0, s_ready}, 32'd0);
    chk("ar_rdata", s_rdata, 32'd0);
    chk("ar_buf_valid", {31'd0, dut.buf_valid_r}, 32'd0);
    @(posedge clk); #1; s_valid = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;

    sb_en = 1'b1;
    run_req(1, 32'h0010_0314, 1'b1, 2);
    run_req(3, 32'h0010_0318, 1'b1, 0);
    sb_en = 1'b0;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
